// File: rtl/maple_pkg.sv
// Shared state encoding, framing constants and pattern helpers for the Maple
// bus transmitter.
package maple_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_END   = 3'd4
  } state_e;

  localparam int START_TICKS   = 10;
  localparam int END_TICKS     = 6;
  localparam int TICKS_PER_BIT = 3;

  // {A,B} levels for one tick of the start pattern
  function automatic logic [1:0] start_level(input logic [3:0] tick);
    logic [1:0] lv;
    if (tick == 4'd0) begin
      lv = 2'b01;
    end else if (tick == 4'(START_TICKS - 1)) begin
      lv = 2'b11;
    end else begin
      lv = {1'b0, ~tick[0]};
    end
    return lv;
  endfunction

  // {A,B} levels for one tick of the end pattern
  function automatic logic [1:0] end_level(input logic [3:0] tick);
    logic [1:0] lv;
    if (tick == 4'd0) begin
      lv = 2'b10;
    end else if (tick == 4'(END_TICKS - 1)) begin
      lv = 2'b11;
    end else begin
      lv = {~tick[0], 1'b0};
    end
    return lv;
  endfunction

endpackage

// File: rtl/maple_fifo.sv
// Byte FIFO for maple_tx: synchronous write and pointer update, head word
// visible on rd_data_o; flush_i empties it in one cycle.
module maple_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          wr_ok_s;
  logic          rd_ok_s;

  assign wr_ok_s   = wr_en_i && !full_o;
  assign rd_ok_s   = rd_en_i && !empty_o;
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == (AW+1)'(0));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage array; unread slots need no reset
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else begin
      if (wr_ok_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/maple_tx.sv
// Maple bus frame transmitter: buffers one frame, then drives the start
// pattern, 3-tick bit cells and end pattern on SDCKA/SDCKB.
// Optional feature macro: MAPLE_TX_CRC_EN appends an XOR checksum byte.
module maple_tx
  import maple_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       sdcka_o,
  output logic       sdckb_o,
  output logic       busy,
  output logic       done,
  output logic       frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(CLK_DIV);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    tick_q, tick_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          a_q, a_d;
  logic          b_q, b_d;
  logic          busy_q;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          fifo_wr_s, fifo_rd_s, fifo_flush_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [7:0]    fifo_head_s;
  logic [AW:0]   fifo_count_s;

  logic          accept_s, active_s, tick_s, more_s;
  logic          clk_lvl_s, dbit_s;
  logic [7:0]    src_s;
  logic [1:0]    cell_s;

`ifdef MAPLE_TX_CRC_EN
  logic [7:0]    crc_q, crc_d;
  logic          crc_pend_q, crc_pend_d;
`endif

  maple_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (fifo_flush_s),
    .wr_en_i   (fifo_wr_s),
    .wr_data_i (s_data),
    .rd_en_i   (fifo_rd_s),
    .rd_data_o (fifo_head_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .count_o   (fifo_count_s)
  );

  // The ready-gate on last_q keeps the next frame out until this one starts
  assign s_ready  = !fifo_full_s &&
                    ((state_q == ST_IDLE) || ((state_q == ST_LOAD) && !last_q));
  assign accept_s = s_valid && s_ready;
  assign active_s = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_END);
  assign tick_s   = active_s && (div_q == DW'(0));

`ifdef MAPLE_TX_CRC_EN
  assign src_s  = fifo_empty_s ? crc_q : fifo_head_s;
  assign more_s = !fifo_empty_s || crc_pend_q;
`else
  assign src_s  = fifo_head_s;
  assign more_s = !fifo_empty_s;
`endif

  // Odd bit indices (7,5,3,1) clock on A; even ones clock on B
  assign clk_lvl_s = (phase_q != 2'd1);
  assign dbit_s    = ((bit_q == 3'd7) && (phase_q == 2'd0)) ? src_s[7] : byte_q[bit_q];
  assign cell_s    = bit_q[0] ? {clk_lvl_s, dbit_s} : {dbit_s, clk_lvl_s};

  // Frame sequencer: next state, FIFO control and line levels
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    tick_d       = tick_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    a_d          = a_q;
    b_d          = b_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    fifo_wr_s    = 1'b0;
    fifo_rd_s    = 1'b0;
    fifo_flush_s = 1'b0;
`ifdef MAPLE_TX_CRC_EN
    crc_d        = crc_q;
    crc_pend_d   = crc_pend_q;
`endif
    if (active_s) begin
      div_d = (div_q == DW'(CLK_DIV - 1)) ? DW'(0) : div_q + DW'(1);
    end else begin
      div_d = DW'(0);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          fifo_wr_s = 1'b1;
          last_d    = s_last;
          state_d   = ST_LOAD;
`ifdef MAPLE_TX_CRC_EN
          crc_d     = s_data;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (last_q) begin
          state_d = ST_START;
          last_d  = 1'b0;
          div_d   = DW'(0);
          tick_d  = 4'd0;
`ifdef MAPLE_TX_CRC_EN
          crc_pend_d = 1'b1;
`endif
        end else if (accept_s) begin
          fifo_wr_s = 1'b1;
          last_d    = s_last;
`ifdef MAPLE_TX_CRC_EN
          crc_d     = crc_q ^ s_data;
`endif
          // A frame that fills the FIFO without s_last can never be sent
          if (!s_last && (fifo_count_s == (AW+1)'(DEPTH - 1))) begin
            fifo_flush_s = 1'b1;
            err_d        = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_START: begin
        if (tick_s) begin
          {a_d, b_d} = start_level(tick_q);
          if (tick_q == 4'(START_TICKS - 1)) begin
            state_d = ST_DATA;
            tick_d  = 4'd0;
            phase_d = 2'd0;
            bit_d   = 3'd7;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end else begin
          state_d = ST_START;
        end
      end

      ST_DATA: begin
        if (tick_s) begin
          {a_d, b_d} = cell_s;
          if ((phase_q == 2'd0) && (bit_q == 3'd7)) begin
            byte_d    = src_s;
            fifo_rd_s = !fifo_empty_s;
`ifdef MAPLE_TX_CRC_EN
            crc_pend_d = crc_pend_q && !fifo_empty_s;
`endif
          end else begin
            byte_d = byte_q;
          end
          if (phase_q != 2'(TICKS_PER_BIT - 1)) begin
            phase_d = phase_q + 2'd1;
          end else begin
            phase_d = 2'd0;
            if (bit_q != 3'd0) begin
              bit_d = bit_q - 3'd1;
            end else if (more_s) begin
              bit_d = 3'd7;
            end else begin
              state_d = ST_END;
              tick_d  = 4'd0;
            end
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_END: begin
        if (tick_s) begin
          {a_d, b_d} = end_level(tick_q);
          if (tick_q == 4'(END_TICKS - 1)) begin
            state_d = ST_IDLE;
            tick_d  = 4'd0;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end else begin
          state_d = ST_END;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame with lines released
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b0;
      div_q      <= DW'(0);
      tick_q     <= 4'd0;
      phase_q    <= 2'd0;
      bit_q      <= 3'd0;
      byte_q     <= 8'd0;
      a_q        <= 1'b1;
      b_q        <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef MAPLE_TX_CRC_EN
      crc_q      <= 8'd0;
      crc_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_END);
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef MAPLE_TX_CRC_EN
      crc_q      <= crc_d;
      crc_pend_q <= crc_pend_d;
`endif
    end
  end

  assign sdcka_o   = a_q;
  assign sdckb_o   = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_maple_tx.sv
// Self-checking bench for maple_tx: random frames compared tick by tick
// against a line-level list built from the bus framing rules.
module tb_maple_tx;

  localparam int DEPTH   = 16;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       sdcka_o;
  logic       sdckb_o;
  logic       busy;
  logic       done;
  logic       frame_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] frame_q [$];
  logic [1:0] lv_q [$];

  always #5 clk = ~clk;

  maple_tx #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .sdcka_o   (sdcka_o),
    .sdckb_o   (sdckb_o),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic rand_frame(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
  endtask

  // Expected {A,B} level for every tick of the frame in frame_q
  task automatic build_levels();
    logic [7:0] bytes_q [$];
    logic       d;
`ifdef MAPLE_TX_CRC_EN
    logic [7:0] x;
`endif
    lv_q.delete();
    bytes_q = frame_q;
`ifdef MAPLE_TX_CRC_EN
    x = 8'h00;
    foreach (frame_q[i]) x = x ^ frame_q[i];
    bytes_q.push_back(x);
`endif
    lv_q.push_back(2'b01);
    for (int i = 1; i <= 8; i++) lv_q.push_back({1'b0, (i % 2 == 0)});
    lv_q.push_back(2'b11);
    foreach (bytes_q[k]) begin
      for (int pos = 0; pos < 8; pos++) begin
        d = bytes_q[k][7 - pos];
        if (pos % 2 == 0) begin
          lv_q.push_back({1'b1, d}); lv_q.push_back({1'b0, d}); lv_q.push_back({1'b1, d});
        end else begin
          lv_q.push_back({d, 1'b1}); lv_q.push_back({d, 1'b0}); lv_q.push_back({d, 1'b1});
        end
      end
    end
    lv_q.push_back(2'b10);
    for (int i = 1; i <= 4; i++) lv_q.push_back({(i % 2 == 0), 1'b0});
    lv_q.push_back(2'b11);
  endtask

  task automatic send_frame(input bit with_last);
    int n;
    n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = frame_q[i];
      s_last  = with_last && (i == n - 1);
      check("load_ready", 32'(s_ready), 32'd1);
      check("load_busy", 32'(busy), 32'd0);
      check("load_lines", 32'({sdcka_o, sdckb_o}), 32'd3);
      @(posedge clk);
      if ((i != n - 1) && ($urandom_range(0, 3) == 0)) begin
        @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("busy_wait", 32'(busy), 32'd0);
    if (!with_last) begin
      check("ovf_err", 32'(frame_err), 32'd1);
      check("ovf_busy", 32'(busy), 32'd0);
      check("ovf_ready", 32'(s_ready), 32'd1);
      check("ovf_lines", 32'({sdcka_o, sdckb_o}), 32'd3);
      @(negedge clk);
      check("ovf_err_pulse", 32'(frame_err), 32'd0);
      check("ovf_lines2", 32'({sdcka_o, sdckb_o}), 32'd3);
    end
  endtask

  task automatic run_frame(input bit hold, input int abort_c);
    int c_end;
    build_levels();
    c_end = 1 + (lv_q.size() - 1) * CLK_DIV;
    @(negedge clk);
    check("busy_start", 32'(busy), 32'd1);
    check("lines_pre", 32'({sdcka_o, sdckb_o}), 32'd3);
    for (int c = 1; c <= c_end + 1; c++) begin
      @(negedge clk);
      check("lines", 32'({sdcka_o, sdckb_o}), 32'(lv_q[(c - 1) / CLK_DIV]));
      check("busy", 32'(busy), 32'(c < c_end));
      check("done", 32'(done), 32'(c == c_end));
      check("frame_err", 32'(frame_err), 32'd0);
      check("s_ready", 32'(s_ready), 32'(c >= c_end));
      if (c == abort_c) begin
        reset = 1'b1;
        @(negedge clk);
        check("abort_lines", 32'({sdcka_o, sdckb_o}), 32'd3);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(s_ready), 32'd1);
        check("abort_done2", 32'(done), 32'd0);
        check("abort_lines2", 32'({sdcka_o, sdckb_o}), 32'd3);
        return;
      end
      if (hold && (c >= 50) && (c < c_end - 8)) begin
        s_valid = 1'b1;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_lines", 32'({sdcka_o, sdckb_o}), 32'd3);
    reset = 1'b0;

    frame_q = '{8'hA5};
    send_frame(1'b1);
    run_frame(1'b0, 0);

    frame_q = '{8'h01, 8'h02, 8'h04};
    send_frame(1'b1);
    run_frame(1'b0, 0);

    for (int r = 0; r < 4; r++) begin
      rand_frame($urandom_range(1, DEPTH));
      send_frame(1'b1);
      run_frame(r == 1, 0);
    end

    rand_frame(DEPTH);
    send_frame(1'b0);

    rand_frame(DEPTH);
    send_frame(1'b1);
    run_frame(1'b0, 0);

    // Abort in the middle of bit 5 of the second byte
    rand_frame(3);
    send_frame(1'b1);
    run_frame(1'b0, 1 + (10 + 24 + 6) * CLK_DIV + 1);

    rand_frame($urandom_range(1, 4));
    send_frame(1'b1);
    run_frame(1'b1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
